// File: rtl/pifo_test_sequencer_pkg.sv
// Shared bench header for the PIFO test sequencer: default widths, counter types and the sequencer state enum.
package pifo_test_sequencer_pkg;

  localparam int COUNTER_W         = 32;
  localparam int PHASE_CYCLES_W    = 16;
  localparam int DRAIN_TIMEOUT_DEF = 4096;

  typedef logic [COUNTER_W-1:0]      counter_signal_t;
  typedef logic [PHASE_CYCLES_W-1:0] phase_cycles_t;

  typedef enum logic [2:0] {
    IDLE,
    GEN,
    DRAIN,
    CHECK,
    DONE
  } seq_state_e;

endpackage

// File: rtl/pifo_test_sequencer_phase_timer.sv
// Loadable down-counter with a zero flag; times GEN windows and the optional drain watchdog.
module pifo_test_sequencer_phase_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pifo_test_sequencer.sv
// PIFO test sequencer: runs fill (GEN) / drain (DRAIN) phases, counts enqueues and dequeues, flags a mismatch.
// Define PIFO_SEQ_TIMEOUT_EN to add the drain watchdog (o__timeout); otherwise DRAIN waits indefinitely.
module pifo_test_sequencer
  import pifo_test_sequencer_pkg::*;
#(
  parameter int CNT_W = COUNTER_W,
  parameter int CYC_W = PHASE_CYCLES_W
`ifdef PIFO_SEQ_TIMEOUT_EN
  ,
  parameter int DRAIN_TIMEOUT = DRAIN_TIMEOUT_DEF
`endif
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i__start,
  input  logic [CNT_W-1:0] i__num_phases,
  input  logic [CYC_W-1:0] i__gen_cycles,
  input  logic             i__enq_valid,
  input  logic             i__pifo_empty,
  input  logic             i__pifo_deq_ready,
  output logic             o__generate_phase,
  output logic [CNT_W-1:0] o__phase_count,
  output logic             o__deq_req,
  output logic             o__busy,
  output logic             o__done,
  output logic [CNT_W-1:0] o__enq_count,
  output logic [CNT_W-1:0] o__deq_count,
  output logic             o__mismatch,
  output logic             o__timeout
);

  seq_state_e       state_q, state_n;
  logic             start_q, start_rise;
  logic             deq_acc, drain_exit, last_phase, phase_inc;
  logic [CNT_W-1:0] num_phases_q, phase_q, enq_q, deq_q;
  logic [CYC_W-1:0] gen_cycles_q, gen_cfg, gen_load_val;
  logic             gen_load, gen_zero, wd_zero;
  logic             gen_phase_q, busy_q, done_q, mismatch_q;

  assign start_rise = i__start && !start_q;
  assign o__deq_req = (state_q == DRAIN) && !i__pifo_empty;
  assign deq_acc    = o__deq_req && i__pifo_deq_ready;
  assign drain_exit = i__pifo_empty && !deq_acc;
  assign last_phase = (phase_q + CNT_W'(1)) == num_phases_q;

  // The timer holds max(gen_cycles,1)-1 so its zero flag marks the last GEN cycle.
  // On the launch edge the config is still on the inputs, not yet in the capture registers.
  assign gen_cfg      = (state_q == IDLE) ? i__gen_cycles : gen_cycles_q;
  assign gen_load_val = (gen_cfg == '0) ? '0 : gen_cfg - CYC_W'(1);
  assign gen_load     = (state_n == GEN) && (state_q != GEN);

  pifo_test_sequencer_phase_timer #(.W(CYC_W)) u_gen_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (gen_load),
    .load_val (gen_load_val),
    .dec      (state_q == GEN),
    .zero     (gen_zero)
  );

`ifdef PIFO_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(DRAIN_TIMEOUT + 1);

  logic timeout_q;

  pifo_test_sequencer_phase_timer #(.W(WD_W)) u_watchdog (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     ((state_n == DRAIN) && (state_q != DRAIN)),
    .load_val (WD_W'(DRAIN_TIMEOUT - 1)),
    .dec      (state_q == DRAIN),
    .zero     (wd_zero)
  );

  // A normal drain exit in the same cycle wins over the watchdog.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      timeout_q <= 1'b0;
    end else if ((state_q == IDLE) && start_rise) begin
      timeout_q <= 1'b0;
    end else if ((state_q == DRAIN) && wd_zero && !drain_exit) begin
      timeout_q <= 1'b1;
    end
  end

  assign o__timeout = timeout_q;
`else
  assign wd_zero    = 1'b0;
  assign o__timeout = 1'b0;
`endif

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_n   = state_q;
    phase_inc = 1'b0;
    case (state_q)
      IDLE:  if (start_rise) state_n = (i__num_phases == '0) ? CHECK : GEN;
      GEN:   if (gen_zero) state_n = DRAIN;
      DRAIN: begin
        if (drain_exit) begin
          if (last_phase) begin
            state_n = CHECK;
          end else begin
            state_n   = GEN;
            phase_inc = 1'b1;
          end
        end else if (wd_zero) begin
          state_n = CHECK;
        end
      end
      CHECK: state_n = DONE;
      DONE:  if (!i__start) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      start_q      <= 1'b0;
      num_phases_q <= '0;
      gen_cycles_q <= '0;
      phase_q      <= '0;
      enq_q        <= '0;
      deq_q        <= '0;
      gen_phase_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      mismatch_q   <= 1'b0;
    end else begin
      state_q     <= state_n;
      start_q     <= i__start;
      gen_phase_q <= (state_n == GEN);
      busy_q      <= (state_n inside {GEN, DRAIN, CHECK});
      done_q      <= (state_n == DONE);

      if ((state_q == IDLE) && start_rise) begin
        num_phases_q <= i__num_phases;
        gen_cycles_q <= i__gen_cycles;
        phase_q      <= '0;
        enq_q        <= '0;
        deq_q        <= '0;
        mismatch_q   <= 1'b0;
      end else begin
        // Both totals saturate rather than wrap.
        if ((state_q != IDLE) && i__enq_valid && (enq_q != '1)) enq_q <= enq_q + CNT_W'(1);
        if (deq_acc && (deq_q != '1)) deq_q <= deq_q + CNT_W'(1);
        if (phase_inc) phase_q <= phase_q + CNT_W'(1);
        if (state_q == CHECK) mismatch_q <= (enq_q != deq_q);
      end
    end
  end

  assign o__generate_phase = gen_phase_q;
  assign o__phase_count    = phase_q;
  assign o__busy           = busy_q;
  assign o__done           = done_q;
  assign o__enq_count      = enq_q;
  assign o__deq_count      = deq_q;
  assign o__mismatch       = mismatch_q;

endmodule

// File: tb/tb_pifo_test_sequencer.sv
// Self-checking bench for pifo_test_sequencer: a queue-depth PIFO model plus per-run tallies set expectations.
module tb_pifo_test_sequencer;

  localparam int CNT_W      = 6;
  localparam int CYC_W      = 16;
  localparam int TB_TIMEOUT = 16;
  localparam int SAT        = (1 << CNT_W) - 1;
  localparam int BUDGET     = 3000;
`ifdef PIFO_SEQ_TIMEOUT_EN
  localparam bit RAND_READY = 1'b0;
`else
  localparam bit RAND_READY = 1'b1;
`endif

  logic             clk = 1'b0;
  logic             reset_n;
  logic             i__start;
  logic [CNT_W-1:0] i__num_phases;
  logic [CYC_W-1:0] i__gen_cycles;
  logic             i__enq_valid;
  logic             i__pifo_empty;
  logic             i__pifo_deq_ready;
  logic             o__generate_phase;
  logic [CNT_W-1:0] o__phase_count;
  logic             o__deq_req;
  logic             o__busy;
  logic             o__done;
  logic [CNT_W-1:0] o__enq_count;
  logic [CNT_W-1:0] o__deq_count;
  logic             o__mismatch;
  logic             o__timeout;

  pifo_test_sequencer #(
    .CNT_W (CNT_W),
    .CYC_W (CYC_W)
`ifdef PIFO_SEQ_TIMEOUT_EN
    ,
    .DRAIN_TIMEOUT (TB_TIMEOUT)
`endif
  ) u_dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .i__start          (i__start),
    .i__num_phases     (i__num_phases),
    .i__gen_cycles     (i__gen_cycles),
    .i__enq_valid      (i__enq_valid),
    .i__pifo_empty     (i__pifo_empty),
    .i__pifo_deq_ready (i__pifo_deq_ready),
    .o__generate_phase (o__generate_phase),
    .o__phase_count    (o__phase_count),
    .o__deq_req        (o__deq_req),
    .o__busy           (o__busy),
    .o__done           (o__done),
    .o__enq_count      (o__enq_count),
    .o__deq_count      (o__deq_count),
    .o__mismatch       (o__mismatch),
    .o__timeout        (o__timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Tallies of the most recent run (PIFO depth, traffic driven, GEN windows seen).
  int occ, enq_all, enq_real, windows, bad_windows, gen_high, drain_req, done_iter;

  function automatic int sat(input int v);
    return (v > SAT) ? SAT : v;
  endfunction

  // Launches one test with start held high, plays TG and PIFO until done, checks totals, returns to IDLE.
  task automatic run_seq(input int n, input int g, input int p, input bit rdy_rand, input bit rdy_val,
                         input bit phantom, input bit exp_to);
    int c, win_len, exp_len, proto_bad, exp_enq, exp_deq, exp_ph, exp_win;
    bit seen_done, gp_prev, enq_now, phantom_now;
    occ = 0; enq_all = 0; enq_real = 0; windows = 0; bad_windows = 0;
    gen_high = 0; drain_req = 0; done_iter = -1;
    win_len = 0; proto_bad = 0; gp_prev = 1'b0; seen_done = 1'b0;
    exp_len = (g == 0) ? 1 : g;
    i__num_phases = CNT_W'(n);
    i__gen_cycles = CYC_W'(g);
    i__start      = 1'b1;
    c = 0;
    while (!seen_done && c < BUDGET) begin
      if (c > 0) begin
        i__num_phases = CNT_W'($urandom);
        i__gen_cycles = CYC_W'($urandom);
      end
      i__pifo_empty     = (occ == 0);
      i__pifo_deq_ready = rdy_rand ? 1'($urandom_range(1)) : rdy_val;
      enq_now     = o__generate_phase && (int'($urandom_range(99)) < p);
      phantom_now = 1'b0;
      if (phantom && o__busy && !o__generate_phase) begin
        enq_now = 1'b1; phantom_now = 1'b1; phantom = 1'b0;
      end
      i__enq_valid = enq_now;
      @(negedge clk);
      if (o__deq_req && (occ == 0)) proto_bad++;
      if (o__deq_req && o__generate_phase) proto_bad++;
      if (o__deq_req) drain_req++;
      if (o__generate_phase) begin
        if (!gp_prev) windows++;
        win_len++;
        gen_high++;
      end else if (gp_prev) begin
        if (win_len != exp_len) bad_windows++;
        win_len = 0;
      end
      gp_prev = o__generate_phase;
      if (o__deq_req && i__pifo_deq_ready) occ--;
      if (enq_now) begin
        enq_all++;
        if (!phantom_now) begin enq_real++; occ++; end
      end
      if (o__done) begin seen_done = 1'b1; done_iter = c; end
      @(posedge clk); #1;
      c++;
    end
    i__enq_valid = 1'b0;

    exp_enq = sat(enq_all);
    exp_deq = exp_to ? 0 : sat(enq_real);
    exp_ph  = (exp_to || n == 0) ? 0 : n - 1;
    exp_win = exp_to ? 1 : n;

    total++;
    if (!seen_done) begin bad++; $display("FAIL run_budget: done not seen in %0d cycles, required done (n=%0d g=%0d)", BUDGET, n, g); end
    total++;
    if ({o__done, o__busy, o__generate_phase, o__deq_req} !== 4'b1000) begin
      bad++; $display("FAIL done_outputs: done/busy/gen/deq=%b required 1000", {o__done, o__busy, o__generate_phase, o__deq_req});
    end
    total++;
    if (o__enq_count !== CNT_W'(exp_enq)) begin bad++; $display("FAIL enq_count: got %0d required %0d", o__enq_count, exp_enq); end
    total++;
    if (o__deq_count !== CNT_W'(exp_deq)) begin bad++; $display("FAIL deq_count: got %0d required %0d", o__deq_count, exp_deq); end
    total++;
    if (o__phase_count !== CNT_W'(exp_ph)) begin bad++; $display("FAIL phase_count: got %0d required %0d", o__phase_count, exp_ph); end
    total++;
    if (o__mismatch !== (exp_enq != exp_deq)) begin bad++; $display("FAIL mismatch: got %b required %b", o__mismatch, exp_enq != exp_deq); end
    total++;
    if (o__timeout !== exp_to) begin bad++; $display("FAIL timeout: got %b required %b", o__timeout, exp_to); end
    total++;
    if (windows != exp_win || bad_windows != 0) begin
      bad++; $display("FAIL gen_windows: got %0d windows (%0d wrong length) required %0d of %0d cycles", windows, bad_windows, exp_win, exp_len);
    end
    total++;
    if (proto_bad != 0) begin bad++; $display("FAIL deq_req_protocol: %0d illegal requests, required 0", proto_bad); end
    if (!exp_to) begin
      total++;
      if (occ != 0) begin bad++; $display("FAIL pifo_drained: depth %0d required 0", occ); end
    end

    repeat (3) begin @(posedge clk); #1; end
    total++;
    if (o__done !== 1'b1) begin bad++; $display("FAIL hold_done: done=%b with start held high, required 1", o__done); end
    i__start = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({o__done, o__busy} !== 2'b00) begin bad++; $display("FAIL return_idle: done/busy=%b required 00", {o__done, o__busy}); end
  endtask

  task automatic test_reset();
    total++;
    if ({o__generate_phase, o__deq_req, o__busy, o__done, o__mismatch, o__timeout,
         o__phase_count, o__enq_count, o__deq_count} !== '0) begin
      bad++; $display("FAIL reset_outputs: got gen=%b deq=%b busy=%b done=%b ph=%0d enq=%0d deq=%0d required all 0",
                      o__generate_phase, o__deq_req, o__busy, o__done, o__phase_count, o__enq_count, o__deq_count);
    end
  endtask

  task automatic test_basic();
    run_seq(3, 10, 100, 1'b0, 1'b1, 1'b0, 1'b0);
    total++;
    if (o__enq_count !== CNT_W'(30) || o__deq_count !== CNT_W'(30) || o__phase_count !== CNT_W'(2) || gen_high != 30) begin
      bad++; $display("FAIL basic_totals: enq=%0d deq=%0d ph=%0d gen_cycles=%0d required 30/30/2/30",
                      o__enq_count, o__deq_count, o__phase_count, gen_high);
    end
  endtask

  task automatic test_zero_phases();
    run_seq(0, 9, 100, 1'b0, 1'b1, 1'b0, 1'b0);
    total++;
    if (done_iter != 2 || gen_high != 0 || drain_req != 0) begin
      bad++; $display("FAIL zero_phases: done after %0d cycles gen=%0d deq_req=%0d required 2/0/0", done_iter, gen_high, drain_req);
    end
  endtask

  task automatic test_gen_zero();
    run_seq(1, 0, 100, 1'b0, 1'b1, 1'b0, 1'b0);
    total++;
    if (gen_high != 1) begin bad++; $display("FAIL gen_zero_len: generate_phase high %0d cycles required 1", gen_high); end
  endtask

  task automatic test_phantom();
    run_seq(1, 6, 100, 1'b0, 1'b1, 1'b1, 1'b0);
    total++;
    if (o__mismatch !== 1'b1 || o__enq_count !== CNT_W'(7) || o__deq_count !== CNT_W'(6)) begin
      bad++; $display("FAIL phantom_enq: mismatch=%b enq=%0d deq=%0d required 1/7/6", o__mismatch, o__enq_count, o__deq_count);
    end
  endtask

  task automatic test_saturation();
    run_seq(7, 10, 100, 1'b0, 1'b1, 1'b0, 1'b0);
    total++;
    if (o__enq_count !== CNT_W'(SAT) || o__deq_count !== CNT_W'(SAT) || o__mismatch !== 1'b0) begin
      bad++; $display("FAIL saturation: enq=%0d deq=%0d mismatch=%b required %0d/%0d/0", o__enq_count, o__deq_count, o__mismatch, SAT, SAT);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      run_seq(int'($urandom_range(4, 1)), int'($urandom_range(12)), int'($urandom_range(100, 30)),
              RAND_READY, 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset_mid_drain();
    int c;
    bit seen;
    occ = 0; c = 0; seen = 1'b0;
    i__num_phases = CNT_W'(2); i__gen_cycles = CYC_W'(5);
    i__pifo_deq_ready = 1'b1; i__start = 1'b1;
    while (!seen && c < 200) begin
      i__pifo_empty = (occ == 0);
      i__enq_valid  = o__generate_phase;
      @(negedge clk);
      if (o__deq_req) begin
        seen = 1'b1;
      end else begin
        if (i__enq_valid) occ++;
        @(posedge clk); #1;
        c++;
      end
    end
    total++;
    if (!seen) begin bad++; $display("FAIL reach_drain: no deq_req within 200 cycles, required DRAIN"); end
    reset_n = 1'b0; i__start = 1'b0; i__enq_valid = 1'b0;
    @(posedge clk); #1;
    test_reset();
    reset_n = 1'b1;
    @(posedge clk); #1;
    run_seq(2, 5, 100, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

`ifdef PIFO_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    run_seq(3, 4, 100, 1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if (drain_req != TB_TIMEOUT || o__mismatch !== 1'b1) begin
      bad++; $display("FAIL watchdog: drain cycles=%0d mismatch=%b required %0d/1", drain_req, o__mismatch, TB_TIMEOUT);
    end
  endtask
`endif

  initial begin
    reset_n = 1'b0; i__start = 1'b0; i__num_phases = '0; i__gen_cycles = '0;
    i__enq_valid = 1'b0; i__pifo_empty = 1'b1; i__pifo_deq_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    reset_n = 1'b1;
    @(posedge clk); #1;
    test_basic();
    test_zero_phases();
    test_gen_zero();
    test_phantom();
    test_saturation();
    test_random();
    test_reset_mid_drain();
`ifdef PIFO_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
